// File: rtl/mmio_arb_pkg.sv
// Shared types and default widths for the two-master FPro MMIO bus arbiter.
package mmio_arb_pkg;

  localparam int unsigned NumMasters   = 2;
  localparam int unsigned DefAddrWidth = 21;
  localparam int unsigned DefDataWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } arb_state_t;

  typedef logic master_idx_t;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-master winner selection: lock first, then single request,
// then round-robin or fixed m0 priority on a tie.
module rr_grant2
  import mmio_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic [NumMasters-1:0] req_i,
  input  master_idx_t           last_grant_i,
  input  logic                  lock_hold_i,
  input  master_idx_t           lock_master_i,
  output master_idx_t           grant_o,
  output logic                  lock_kept_o
);

  always_comb begin
    grant_o     = 1'b0;
    lock_kept_o = lock_hold_i && req_i[lock_master_i];
    if (lock_kept_o) begin
      grant_o = lock_master_i;
    end else if (req_i == 2'b10) begin
      grant_o = 1'b1;
    end else if (req_i == 2'b11) begin
      grant_o = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_i;
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares one FPro MMIO bus between two masters; each transaction runs
// IDLE -> ISSUE -> RESP with a one-cycle strobe and a one-cycle ack.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
  parameter int unsigned BUS_DATA_WIDTH = DefDataWidth,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      m0_req,
  input  logic                      m0_wr,
  input  logic                      m0_lock,
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [BUS_DATA_WIDTH-1:0] m0_wr_data,
  output logic                      m0_ack,
  output logic [BUS_DATA_WIDTH-1:0] m0_rd_data,
  input  logic                      m1_req,
  input  logic                      m1_wr,
  input  logic                      m1_lock,
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [BUS_DATA_WIDTH-1:0] m1_wr_data,
  output logic                      m1_ack,
  output logic [BUS_DATA_WIDTH-1:0] m1_rd_data,
  output logic                      fp_mmio_cs,
  output logic                      fp_rd,
  output logic                      fp_wr,
  output logic [ADDR_WIDTH-1:0]     fp_addr,
  output logic [BUS_DATA_WIDTH-1:0] fp_wr_data,
  input  logic [BUS_DATA_WIDTH-1:0] fp_rd_data
);

  arb_state_t                state_q, state_d;
  master_idx_t               grant_q, grant_d;
  master_idx_t               last_grant_q, last_grant_d;
  logic                      lock_hold_q, lock_hold_d;
  logic                      cs_q, cs_d;
  logic                      rd_q, rd_d;
  logic                      wr_q, wr_d;
  logic                      ack0_q, ack0_d;
  logic                      ack1_q, ack1_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BUS_DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [BUS_DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic [NumMasters-1:0] req;
  master_idx_t           win;
  logic                  lock_kept;

  assign req = {m1_req, m0_req};

  // The locked master is always the one granted last.
  rr_grant2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_grant (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .lock_hold_i  (lock_hold_q),
    .lock_master_i(last_grant_q),
    .grant_o      (win),
    .lock_kept_o  (lock_kept)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    lock_hold_d  = lock_hold_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    cs_d         = 1'b0;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d     = win;
          lock_hold_d = lock_kept;
          cs_d        = 1'b1;
          if (win) begin
            wr_d    = m1_wr;
            rd_d    = ~m1_wr;
            addr_d  = m1_addr;
            wdata_d = m1_wr_data;
          end else begin
            wr_d    = m0_wr;
            rd_d    = ~m0_wr;
            addr_d  = m0_addr;
            wdata_d = m0_wr_data;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (rd_q) begin
          if (grant_q) begin
            rdata1_d = fp_rd_data;
          end else begin
            rdata0_d = fp_rd_data;
          end
        end
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = StResp;
      end
      StResp: begin
        last_grant_d = grant_q;
        lock_hold_d  = grant_q ? m1_lock : m0_lock;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_hold_q  <= 1'b0;
      cs_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      lock_hold_q  <= lock_hold_d;
      cs_q         <= cs_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign fp_mmio_cs = cs_q;
  assign fp_rd      = rd_q;
  assign fp_wr      = wr_q;
  assign fp_addr    = addr_q;
  assign fp_wr_data = wdata_q;
  assign m0_ack     = ack0_q;
  assign m1_ack     = ack1_q;
  assign m0_rd_data = rdata0_q;
  assign m1_rd_data = rdata1_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench for mmio_bus_arbiter: drivers queue expected transactions,
// a negedge monitor checks each bus strobe and ack against an arbitration model.
module tb_mmio_bus_arbiter;

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_req = 1'b0, m0_wr = 1'b0, m0_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wr_data = '0;
  logic          m1_req = 1'b0, m1_wr = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wr_data = '0;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          fp_mmio_cs, fp_rd, fp_wr;
  logic [AW-1:0] fp_addr;
  logic [DW-1:0] fp_wr_data, fp_rd_data;
  logic [DW-1:0] junk = '0;

  // Second instance with fixed priority.
  logic          f_m0_req = 1'b0, f_m0_wr = 1'b0, f_m0_lock = 1'b0;
  logic [AW-1:0] f_m0_addr = '0;
  logic [DW-1:0] f_m0_wr_data = '0;
  logic          f_m1_req = 1'b0, f_m1_wr = 1'b0, f_m1_lock = 1'b0;
  logic [AW-1:0] f_m1_addr = '0;
  logic [DW-1:0] f_m1_wr_data = '0;
  logic          f_m0_ack, f_m1_ack;
  logic [DW-1:0] f_m0_rd_data, f_m1_rd_data;
  logic          f_fp_mmio_cs, f_fp_rd, f_fp_wr;
  logic [AW-1:0] f_fp_addr;
  logic [DW-1:0] f_fp_wr_data, f_fp_rd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [1:0] req_s = 2'b00;

  txn_t q0[$];
  txn_t q1[$];
  int grant_log[$];
  int strobe_cyc[$];
  logic [DW-1:0] mdl_rd0 = '0, mdl_rd1 = '0;
  int mdl_last = 1;
  bit mdl_lock_v = 1'b0;
  int mdl_lock_m = 0;
  bit pend = 1'b0;
  int pend_m = 0;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.ADDR_WIDTH(AW), .BUS_DATA_WIDTH(DW), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .fp_mmio_cs(fp_mmio_cs), .fp_rd(fp_rd), .fp_wr(fp_wr), .fp_addr(fp_addr),
    .fp_wr_data(fp_wr_data), .fp_rd_data(fp_rd_data)
  );

  mmio_bus_arbiter #(.ADDR_WIDTH(AW), .BUS_DATA_WIDTH(DW), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_req(f_m0_req), .m0_wr(f_m0_wr), .m0_lock(f_m0_lock), .m0_addr(f_m0_addr),
    .m0_wr_data(f_m0_wr_data), .m0_ack(f_m0_ack), .m0_rd_data(f_m0_rd_data),
    .m1_req(f_m1_req), .m1_wr(f_m1_wr), .m1_lock(f_m1_lock), .m1_addr(f_m1_addr),
    .m1_wr_data(f_m1_wr_data), .m1_ack(f_m1_ack), .m1_rd_data(f_m1_rd_data),
    .fp_mmio_cs(f_fp_mmio_cs), .fp_rd(f_fp_rd), .fp_wr(f_fp_wr), .fp_addr(f_fp_addr),
    .fp_wr_data(f_fp_wr_data), .fp_rd_data(f_fp_rd_data)
  );

  // Slave model: read data is a fixed function of address, garbage when not reading.
  function automatic logic [DW-1:0] slv(input logic [AW-1:0] a);
    if (a == 21'h00010) return 32'hDEADBEEF;
    return ({11'h0, a} * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  always_comb fp_rd_data = fp_rd ? slv(fp_addr) : junk;
  always_comb f_fp_rd_data = slv(f_fp_addr);

  always @(negedge clk) junk <= $urandom;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    req_s <= {m1_req, m0_req};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    txn_t t;
    int   w;
    bit   r0, r1, has;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q0.delete();
        q1.delete();
        pend       = 1'b0;
        mdl_rd0    = '0;
        mdl_rd1    = '0;
        mdl_last   = 1;
        mdl_lock_v = 1'b0;
      end else begin
        if (pend) begin
          chk("ack_target", {m1_ack, m0_ack}, (pend_m == 1) ? 2'b10 : 2'b01);
          if (pend_m == 0) begin
            t = q0.pop_front();
            if (!t.wr) mdl_rd0 = slv(t.addr);
            mdl_lock_v = m0_lock;
          end else begin
            t = q1.pop_front();
            if (!t.wr) mdl_rd1 = slv(t.addr);
            mdl_lock_v = m1_lock;
          end
          mdl_last   = pend_m;
          mdl_lock_m = pend_m;
          chk("m0_rd_data", m0_rd_data, mdl_rd0);
          chk("m1_rd_data", m1_rd_data, mdl_rd1);
          pend = 1'b0;
        end else if (m0_ack || m1_ack) begin
          chk("spurious_ack", {m1_ack, m0_ack}, 2'b00);
        end
        if (fp_mmio_cs || fp_rd || fp_wr) begin
          chk("strobe_shape", {fp_mmio_cs, fp_rd ^ fp_wr}, 2'b11);
          r0 = req_s[0];
          r1 = req_s[1];
          chk("strobe_has_req", r0 | r1, 1'b1);
          if (mdl_lock_v && ((mdl_lock_m == 1) ? r1 : r0)) begin
            w = mdl_lock_m;
          end else begin
            mdl_lock_v = 1'b0;
            if (r0 && !r1)      w = 0;
            else if (r1 && !r0) w = 1;
            else                w = 1 - mdl_last;
          end
          has = (w == 0) ? (q0.size() != 0) : (q1.size() != 0);
          chk("winner_pending", has, 1'b1);
          if (has) begin
            t = (w == 0) ? q0[0] : q1[0];
            chk("fp_wr", fp_wr, t.wr);
            chk("fp_addr", fp_addr, t.addr);
            chk("fp_wr_data", fp_wr_data, t.data);
            pend   = 1'b1;
            pend_m = w;
            grant_log.push_back(w);
            strobe_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  // Starts at 1 time unit after a rising edge and returns at the same phase,
  // in the cycle after the ack, with req dropped.
  task automatic do_txn(input int m, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic lk, input int gap);
    txn_t t;
    bit   got;
    got = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    t.wr   = wr;
    t.addr = a;
    t.data = d;
    if (m == 0) begin
      m0_wr = wr; m0_addr = a; m0_wr_data = d; m0_lock = lk; m0_req = 1'b1;
      q0.push_back(t);
    end else begin
      m1_wr = wr; m1_addr = a; m1_wr_data = d; m1_lock = lk; m1_req = 1'b1;
      q1.push_back(t);
    end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if ((m == 0) ? m0_ack : m1_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk((m == 0) ? "m0_ack_arrived" : "m1_ack_arrived", got, 1'b1);
    @(posedge clk);
    #1;
    if (m == 0) begin
      m0_req = 1'b0; m0_lock = 1'b0;
    end else begin
      m1_req = 1'b0; m1_lock = 1'b0;
    end
  endtask

  task automatic rand_txn(input int m);
    logic          wr, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            gap;
    wr  = 1'($urandom_range(0, 1));
    lk  = ($urandom_range(0, 3) == 0);
    a   = AW'($urandom);
    d   = $urandom;
    gap = int'($urandom_range(0, 3));
    do_txn(m, wr, a, d, lk, gap);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  n0, n1, nstr;
    bit  got;
    // Reset state
    @(posedge clk);
    #1;
    chk("rst_ctrl", {m0_ack, m1_ack, fp_mmio_cs, fp_rd, fp_wr}, 5'b0);
    chk("rst_rd_data", {m0_rd_data, m1_rd_data}, 64'h0);
    chk("rst_fp_addr", fp_addr, 21'h0);
    chk("rst_fp_wr_data", fp_wr_data, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single read and single write
    do_txn(0, 1'b0, 21'h00010, 32'h0, 1'b0, 0);
    chk("t1_rd_data", m0_rd_data, 32'hDEADBEEF);
    do_txn(1, 1'b0, 21'h00200, 32'h0, 1'b0, 1);
    do_txn(1, 1'b1, 21'h00104, 32'h0000A5A5, 1'b0, 0);
    chk("t2_rd_unchanged", m1_rd_data, slv(21'h00200));

    // Continuous contention, round-robin
    repeat (2) @(posedge clk);
    #1;
    grant_log.delete();
    strobe_cyc.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) do_txn(0, 1'b0, AW'(21'h1000 + i), 32'h0, 1'b0, 0);
      end
      begin
        for (int i = 0; i < 3; i++) do_txn(1, 1'b1, AW'(21'h2000 + i), $urandom, 1'b0, 0);
      end
    join
    chk("rr_count", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size() && i < 6; i++) chk("rr_order", grant_log[i], i % 2);
    for (int i = 1; i < strobe_cyc.size(); i++)
      chk("rr_spacing", strobe_cyc[i] - strobe_cyc[i-1], 3);

    // Lock: m1 keeps the bus for its back-to-back second transaction
    repeat (2) @(posedge clk);
    #1;
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) do_txn(0, 1'b0, AW'(21'h3000 + i), 32'h0, 1'b0, 0);
      end
      begin
        do_txn(1, 1'b0, 21'h04000, 32'h0, 1'b1, 0);
        do_txn(1, 1'b1, 21'h04004, 32'h5555AAAA, 1'b0, 0);
      end
    join
    chk("lock_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      chk("lock_g0", grant_log[0], 0);
      chk("lock_g1", grant_log[1], 1);
      chk("lock_g2", grant_log[2], 1);
      chk("lock_g3", grant_log[3], 0);
      chk("lock_g4", grant_log[4], 0);
    end

    // Randomized traffic from both masters
    fork
      begin
        repeat (40) rand_txn(0);
      end
      begin
        repeat (40) rand_txn(1);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", q0.size() + q1.size(), 0);

    // Reset during ISSUE of an m0 read
    m0_wr = 1'b0; m0_addr = 21'h00777; m0_lock = 1'b0; m0_req = 1'b1;
    begin : push_pre
      txn_t t;
      t.wr = 1'b0; t.addr = 21'h00777; t.data = m0_wr_data;
      q0.push_back(t);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (fp_rd) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached_issue", got, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {m0_ack, m1_ack, fp_mmio_cs, fp_rd, fp_wr}, 5'b0);
    chk("rst_mid_rd_data", {m0_rd_data, m1_rd_data}, 64'h0);
    chk("rst_mid_fp_addr", fp_addr, 21'h0);
    chk("rst_mid_fp_wr_data", fp_wr_data, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_no_ack", m0_ack, 1'b0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    begin : push_post
      txn_t t;
      t.wr = 1'b0; t.addr = 21'h00777; t.data = m0_wr_data;
      q0.push_back(t);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (m0_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_mid_fresh_ack", got, 1'b1);
    chk("rst_mid_rd_after", m0_rd_data, slv(21'h00777));
    @(posedge clk);
    #1;
    m0_req = 1'b0;

    // Fixed priority: m0 wins every tie while it keeps requesting
    f_m0_wr = 1'b0; f_m0_addr = 21'h00300; f_m0_wr_data = 32'h11112222;
    f_m1_wr = 1'b0; f_m1_addr = 21'h00404; f_m1_wr_data = 32'h33334444;
    f_m0_req = 1'b1;
    f_m1_req = 1'b1;
    n0 = 0; n1 = 0; nstr = 0;
    for (int i = 0; i < 60 && n0 < 6; i++) begin
      @(posedge clk);
      #1;
      if (f_m0_ack) n0++;
      if (f_m1_ack) n1++;
      if (f_fp_mmio_cs) begin
        nstr++;
        if (nstr == 1) begin
          chk("fp_strobe_kind", {f_fp_rd, f_fp_wr}, 2'b10);
          chk("fp_strobe_addr", f_fp_addr, 21'h00300);
          chk("fp_strobe_wdata", f_fp_wr_data, 32'h11112222);
        end
      end
    end
    chk("fp_m0_grants", n0, 6);
    chk("fp_m1_starved", n1, 0);
    chk("fp_m0_rd", f_m0_rd_data, slv(21'h00300));
    f_m0_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (f_m1_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("fp_m1_served", got, 1'b1);
    chk("fp_m1_rd", f_m1_rd_data, slv(21'h00404));
    @(posedge clk);
    #1;
    f_m1_req = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
